// File: rtl/song_pkg.sv
// Shared types and defaults for the song sequencer.
// Holds the FSM state encoding and the built-in melody table.
package song_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TONE_W = 4;
  localparam int DEF_LEN    = 32;
  localparam int DEF_IDX_W  = 8;
  localparam int DEF_DIV_W  = 16;

  localparam int ROM_DEPTH  = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_PAUSE,
    S_DONE
  } state_t;

  // Four channels of 4-bit tones per beat, channel 0 in the top nibble.
  localparam logic [15:0] BEATS [ROM_DEPTH] = '{
    16'h33A1, 16'h0000, 16'h33A0, 16'h3390,
    16'h70C1, 16'h7080, 16'h5571, 16'h5570,
    16'h4461, 16'h4460, 16'h3351, 16'h0000,
    16'h2241, 16'h2240, 16'h1131, 16'h1130,
    16'h33A1, 16'h0000, 16'h33A0, 16'h3390,
    16'h70C1, 16'h7080, 16'h5571, 16'h5570,
    16'h4461, 16'h4460, 16'h3351, 16'h3350,
    16'h2241, 16'h2240, 16'h1131, 16'h0000
  };

endpackage

// File: rtl/song_sequencer_if.sv
// Control/status bundle between a host and the song sequencer.
// The host drives requests and tempo; the sequencer returns tones.
interface song_sequencer_if
  import song_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TONE_W = DEF_TONE_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DIV_W  = DEF_DIV_W
);

  logic                       play;
  logic                       pause;
  logic                       stop;
  logic                       loop_en;
  logic [DIV_W-1:0]           tempo;
  logic [NUM_CH*TONE_W-1:0]   tones;
  logic [IDX_W-1:0]           note_index;
  logic                       playing;
  logic                       song_done;

  modport master (
    output play,
    output pause,
    output stop,
    output loop_en,
    output tempo,
    input  tones,
    input  note_index,
    input  playing,
    input  song_done
  );

  modport slave (
    input  play,
    input  pause,
    input  stop,
    input  loop_en,
    input  tempo,
    output tones,
    output note_index,
    output playing,
    output song_done
  );

endinterface

// File: rtl/song_sequencer_rom.sv
// Combinational melody lookup: step index to packed channel beat.
// Indices past the song length or the table depth read as silence.
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TONE_W = DEF_TONE_W,
  parameter int LEN    = DEF_LEN,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic [IDX_W-1:0]           i_idx,
  output logic [NUM_CH*TONE_W-1:0]   o_beat
);

  localparam int W = NUM_CH * TONE_W;

  logic [4:0] w_sel;

  assign w_sel = 5'(i_idx);

  always_comb begin
    o_beat = '0;
    if (int'(i_idx) < LEN && int'(i_idx) < ROM_DEPTH) begin
      o_beat = W'(BEATS[w_sel]);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Tempo-driven step sequencer that plays the melody table.
// Request priority is stop > pause > play in every state.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TONE_W = DEF_TONE_W,
  parameter int LEN    = DEF_LEN,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input logic              clk,
  input logic              reset_n,
  song_sequencer_if.slave  bus
);

  localparam int W = NUM_CH * TONE_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LEN - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [DIV_W-1:0]  r_pre;
  logic [W-1:0]      r_tones;
  logic              r_done;

  logic [W-1:0]      w_beat;
  logic              w_step;

  song_rom #(
    .NUM_CH (NUM_CH),
    .TONE_W (TONE_W),
    .LEN    (LEN),
    .IDX_W  (IDX_W)
  ) u_rom (
    .i_idx  (r_idx),
    .o_beat (w_beat)
  );

  // >= so that lowering tempo below the running count steps at once
  assign w_step = r_pre >= bus.tempo;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_pre   <= '0;
      r_tones <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_tones <= '0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
          end else if (!bus.pause && bus.play) begin
            r_state <= S_PLAY;
            r_idx   <= '0;
            r_pre   <= '0;
          end
        end
        S_PLAY: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
          end else if (bus.pause) begin
            r_state <= S_PAUSE;
          end else begin
            r_tones <= w_beat;
            if (w_step) begin
              r_pre <= '0;
              if (r_idx < LAST) begin
                r_idx <= r_idx + 1'b1;
              end else if (bus.loop_en) begin
                r_idx <= '0;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_tones <= '0;
              end
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
        end
        S_PAUSE: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pre   <= '0;
          end else if (!bus.pause && bus.play) begin
            r_state <= S_PLAY;
          end
        end
      endcase
    end
  end

  assign bus.tones      = r_tones;
  assign bus.note_index = r_idx;
  assign bus.playing    = (r_state == S_PLAY);
  assign bus.song_done  = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: vector table, directed corners and
// a randomized run against a cycle-level behavioural model.
module tb_song_sequencer;

  localparam int MI = 0;
  localparam int MP = 1;
  localparam int MZ = 2;
  localparam int MD = 3;

  localparam bit [15:0] TB_ROM [32] = '{
    16'h33A1, 16'h0000, 16'h33A0, 16'h3390,
    16'h70C1, 16'h7080, 16'h5571, 16'h5570,
    16'h4461, 16'h4460, 16'h3351, 16'h0000,
    16'h2241, 16'h2240, 16'h1131, 16'h1130,
    16'h33A1, 16'h0000, 16'h33A0, 16'h3390,
    16'h70C1, 16'h7080, 16'h5571, 16'h5570,
    16'h4461, 16'h4460, 16'h3351, 16'h3350,
    16'h2241, 16'h2240, 16'h1131, 16'h0000
  };

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  song_sequencer_if #(.NUM_CH(4), .TONE_W(4), .IDX_W(8), .DIV_W(16)) ifa ();
  song_sequencer_if #(.NUM_CH(4), .TONE_W(4), .IDX_W(8), .DIV_W(16)) ifb ();

  song_sequencer #(
    .NUM_CH(4), .TONE_W(4), .LEN(32), .IDX_W(8), .DIV_W(16)
  ) dut_a (
    .clk     (clk),
    .reset_n (rst_a),
    .bus     (ifa.slave)
  );

  song_sequencer #(
    .NUM_CH(4), .TONE_W(4), .LEN(5), .IDX_W(8), .DIV_W(16)
  ) dut_b (
    .clk     (clk),
    .reset_n (rst_b),
    .bus     (ifb.slave)
  );

  typedef struct {
    bit          rn;
    bit          pl;
    bit          pa;
    bit          st;
    bit          lp;
    int          tp;
    int          e_idx;
    bit          e_play;
    bit          e_done;
    logic [15:0] e_tones;
  } vec_t;

  vec_t tv [13];

  int m_mode;
  int m_idx;
  int m_cnt;
  bit m_done;
  bit [15:0] m_tones;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input bit pl, input bit pa, input bit st,
                         input bit lp, input int tp);
    ifa.play    = pl;
    ifa.pause   = pa;
    ifa.stop    = st;
    ifa.loop_en = lp;
    ifa.tempo   = 16'(tp);
  endtask

  task automatic chk_a(input string nm, input int idx, input bit pl,
                       input bit dn, input logic [15:0] tn);
    chk({nm, ".idx"},  32'(ifa.note_index), 32'(idx));
    chk({nm, ".play"}, 32'(ifa.playing),    32'(pl));
    chk({nm, ".done"}, 32'(ifa.song_done),  32'(dn));
    chk({nm, ".tone"}, 32'(ifa.tones),      32'(tn));
  endtask

  // One clock of the song rules, len = number of steps.
  task automatic model_step(input int len, input bit rn, input bit pl,
                            input bit pa, input bit st, input bit lp,
                            input int tp);
    int old_mode = m_mode;
    int old_idx  = m_idx;
    m_done = 1'b0;
    if (!rn || st) begin
      m_mode = MI;
      m_idx  = 0;
      m_cnt  = 0;
    end else if (pa) begin
      if (m_mode == MP) m_mode = MZ;
    end else if (pl && m_mode != MP) begin
      if (m_mode == MZ) begin
        m_mode = MP;
      end else begin
        m_mode = MP;
        m_idx  = 0;
        m_cnt  = 0;
      end
    end else if (m_mode == MP) begin
      if (m_cnt >= tp) begin
        m_cnt = 0;
        if (m_idx < len - 1) m_idx++;
        else if (lp) m_idx = 0;
        else begin
          m_mode = MD;
          m_done = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
    if (rn && old_mode == MP && m_mode == MP) m_tones = TB_ROM[old_idx];
    else m_tones = 16'h0;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    ifb.play = 0; ifb.pause = 0; ifb.stop = 0;
    ifb.loop_en = 0; ifb.tempo = 16'd0;

    //        rn pl pa st lp tp  idx pl dn tones
    tv[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000};
    tv[1]  = '{1, 1, 0, 0, 0, 0,  0, 1, 0, 16'h0000};
    tv[2]  = '{1, 0, 0, 0, 0, 0,  1, 1, 0, 16'h33A1};
    tv[3]  = '{1, 0, 0, 0, 0, 0,  2, 1, 0, 16'h0000};
    tv[4]  = '{1, 0, 0, 0, 0, 0,  3, 1, 0, 16'h33A0};
    tv[5]  = '{1, 0, 0, 0, 0, 0,  4, 1, 0, 16'h3390};
    tv[6]  = '{1, 1, 0, 0, 0, 0,  5, 1, 0, 16'h70C1};
    tv[7]  = '{1, 1, 1, 1, 0, 0,  0, 0, 0, 16'h0000};
    tv[8]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000};
    tv[9]  = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 16'h0000};
    tv[10] = '{1, 1, 0, 0, 0, 0,  0, 1, 0, 16'h0000};
    tv[11] = '{1, 0, 0, 0, 0, 0,  1, 1, 0, 16'h33A1};
    tv[12] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000};

    for (int i = 0; i < 13; i++) begin
      rst_a = tv[i].rn;
      drive_a(tv[i].pl, tv[i].pa, tv[i].st, tv[i].lp, tv[i].tp);
      tick();
      chk_a($sformatf("vec%0d", i), tv[i].e_idx, tv[i].e_play,
            tv[i].e_done, tv[i].e_tones);
    end

    // Full song at tempo 3, no loop
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(0, 0, 1, 0, 3);
    tick();
    drive_a(1, 0, 0, 0, 3);
    tick();
    drive_a(0, 0, 0, 0, 3);
    for (int k = 0; k < 128; k++) begin
      chk("t3.idx", 32'(ifa.note_index), 32'(k / 4));
      chk("t3.done", 32'(ifa.song_done), 32'd0);
      tick();
    end
    chk_a("t3.end", 31, 0, 1, 16'h0000);
    tick();
    chk_a("t3.hold", 31, 0, 0, 16'h0000);

    // Looping at tempo 0
    drive_a(0, 0, 1, 1, 0);
    tick();
    drive_a(1, 0, 0, 1, 0);
    tick();
    drive_a(0, 0, 0, 1, 0);
    for (int k = 0; k < 70; k++) begin
      chk("loop.idx", 32'(ifa.note_index), 32'(k % 32));
      chk("loop.done", 32'(ifa.song_done), 32'd0);
      tick();
    end

    // Pause mid-step at index 5 with two prescaler counts used
    drive_a(0, 0, 1, 0, 3);
    tick();
    drive_a(1, 0, 0, 0, 3);
    tick();
    drive_a(0, 0, 0, 0, 3);
    for (int k = 0; k < 22; k++) tick();
    chk("pz.pre", 32'(ifa.note_index), 32'd5);
    drive_a(0, 1, 0, 0, 3);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_a("pz.hold", 5, 0, 0, 16'h0000);
    end
    drive_a(1, 0, 0, 0, 3);
    tick();
    drive_a(0, 0, 0, 0, 3);
    chk("pz.r0", 32'(ifa.note_index), 32'd5);
    chk("pz.rp", 32'(ifa.playing), 32'd1);
    tick();
    chk("pz.r1", 32'(ifa.note_index), 32'd5);
    tick();
    chk("pz.r2", 32'(ifa.note_index), 32'd6);

    // LEN=5: tempo 9 cut to 2 with prescaler at 7
    ifb.tempo = 16'd9;
    ifb.play = 1'b1;
    tick();
    ifb.play = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("l5.pre", 32'(ifb.note_index), 32'd0);
    ifb.tempo = 16'd2;
    tick();
    for (int i = 1; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        chk("l5.idx", 32'(ifb.note_index), 32'(i));
        chk("l5.play", 32'(ifb.playing), 32'd1);
        tick();
      end
    end
    chk("l5.done", 32'(ifb.song_done), 32'd1);
    chk("l5.didx", 32'(ifb.note_index), 32'd4);
    chk("l5.dplay", 32'(ifb.playing), 32'd0);
    tick();
    chk("l5.once", 32'(ifb.song_done), 32'd0);
    chk("l5.hidx", 32'(ifb.note_index), 32'd4);

    // Randomized run against the model
    begin
      int tp = 0;
      bit rn, pl, pa, st, lp;
      m_mode = MI; m_idx = 0; m_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
        rn = (n == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
        st = ($urandom_range(0, 79) == 0);
        pa = ($urandom_range(0, 24) == 0);
        pl = ($urandom_range(0, 9) == 0);
        lp = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) tp = $urandom_range(0, 3);
        rst_a = rn;
        drive_a(pl, pa, st, lp, tp);
        tick();
        model_step(32, rn, pl, pa, st, lp, tp);
        chk_a("rnd", m_idx, (m_mode == MP), m_done, m_tones);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of simultaneous tone channels.
REQ-002 SHALL have parameter TONE_W, default 4: bits per channel tone code.
REQ-003 SHALL have parameter LEN, default 32: number of song steps, any value 2..2**IDX_W.
REQ-004 SHALL have parameter IDX_W, default 8: width of note_index.
REQ-005 SHALL have parameter DIV_W, default 16: width of tempo.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port play, input, 1: start, resume or restart request.
REQ-009 SHALL have port pause, input, 1: pause request.
REQ-010 SHALL have port stop, input, 1: stop request; returns to idle.
REQ-011 SHALL have port loop_en, input, 1: wrap to step 0 after the last step instead of finishing.
REQ-012 SHALL have port tempo, input, DIV_W: clock cycles per step minus 1.
REQ-013 SHALL have port tones, output, NUM_CH*TONE_W: packed channel tones, channel 0 in the MSBs.
REQ-014 SHALL have port note_index, output, IDX_W: current step.
REQ-015 SHALL have port playing, output, 1: high in PLAY only.
REQ-016 SHALL have port song_done, output, 1: one-cycle pulse on song completion.

Function
REQ-017 SHALL implement the states IDLE, PLAY, PAUSE and DONE.
REQ-018 SHALL resolve simultaneous requests with priority stop > pause > play in every state.
REQ-019 SHALL, in IDLE or DONE with play=1, enter PLAY next cycle with note_index=0 and prescaler=0.
REQ-020 SHALL, in PLAY, increment the prescaler each cycle and generate a step when prescaler >= tempo, clearing the prescaler, so each step lasts tempo+1 cycles (tempo=0 gives one step per cycle).
REQ-021 SHALL, on a step with note_index<LEN-1, increment note_index.
REQ-022 SHALL, on a step with note_index=LEN-1 and loop_en=1, set note_index to 0 and stay in PLAY; loop_en is sampled only on that cycle.
REQ-023 SHALL, on a step with note_index=LEN-1 and loop_en=0, enter DONE, hold note_index at LEN-1, and assert song_done for exactly the first DONE cycle.
REQ-024 SHALL, in PLAY with pause=1, enter PAUSE holding note_index and the prescaler; in PAUSE, play=1 returns to PLAY resuming from the held prescaler value.
REQ-025 SHALL, on stop=1 in any state, enter IDLE next cycle with note_index=0 and prescaler=0.
REQ-026 SHALL ignore play while already in PLAY.
REQ-027 SHALL drive tones as a register equal to rom[note_index] of the previous cycle while in PLAY, and 0 in IDLE, PAUSE (muted) and DONE.
REQ-028 SHALL, for a tempo change mid-step, use the new value on the next cycle; if the prescaler already exceeds the new tempo, step immediately.
REQ-029 SHALL never let note_index exceed LEN-1, including when LEN is not a power of two.

Reset
REQ-030 SHALL, with reset_n=0 at a clock edge, set state=IDLE, note_index=0, prescaler=0, tones=0, playing=0, song_done=0; reset overrides all requests, including mid-song.

Structure
REQ-031 SHALL place the state enumeration and the default parameter constants in shared package song_pkg.
REQ-032 SHALL contain a single sub-module, song_rom: a combinational lookup from index to an NUM_CH*TONE_W beat, returning 0 for out-of-range indices.
REQ-033 SHALL have song_rom default content with entry 0=0x33A1, entry 1=0x0000, entry 2=0x33A0, entry 4=0x70C1, entry 31=0x0000.

Verification
REQ-034 SHALL cover: reset, then play pulse with tempo=0 -> playing=1 next cycle, note_index 0,1,2… one per cycle, tones=0x33A1 one cycle after index 0.
REQ-035 SHALL cover: tempo=3, loop_en=0, play -> each index held 4 cycles; after index 31 -> song_done high 1 cycle, playing=0, tones=0, index held 31.
REQ-036 SHALL cover: loop_en=1, tempo=0 -> index 31 followed by 0, song_done never asserted.
REQ-037 SHALL cover: pause at index 5 mid-step -> tones=0 and index 5 held 10 cycles; play -> remaining prescaler count completes before step to 6.
REQ-038 SHALL cover: stop, pause and play asserted together in PLAY -> IDLE with index 0; reset_n low mid-song -> all outputs 0 next cycle.
REQ-039 SHALL cover: LEN=5, tempo=9, prescaler at 7 when tempo changes to 2 -> immediate step; index sequence 0..4 then DONE.
